// File: rtl/norm_pkg.sv
// Shared types and constants for the per-lane normaliser (norm_pipe).
// Contents: FSM state enum, pipeline depth, saturation bound helpers.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } norm_state_e;

    // Register stages between in_valid and out_valid.
    localparam int unsigned PIPE_DEPTH = 3;

    // Largest two's-complement value of a w-bit signed number.
    function automatic int sat_max(input int unsigned w);
        int r;
        r = 1;
        r = r << (w - 1);
        return r - 1;
    endfunction

    // Smallest two's-complement value of a w-bit signed number.
    function automatic int sat_min(input int unsigned w);
        return -sat_max(w) - 1;
    endfunction

endpackage

// File: rtl/norm_if.sv
// Vector stream bundle between the systolic array, norm_pipe and the pooling stage.
// Signals:
//   in_valid, inp_data, validity_mask : producer -> norm_pipe
//   out_valid, out_data, done_norm    : norm_pipe -> consumer
// master = stimulus/producer side, slave = norm_pipe side.
interface norm_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned LANES  = 16
);
    logic                      in_valid;
    logic [LANES*DWIDTH-1:0]   inp_data;
    logic [LANES-1:0]          validity_mask;
    logic                      out_valid;
    logic [LANES*DWIDTH-1:0]   out_data;
    logic                      done_norm;

    modport master (
        output in_valid, inp_data, validity_mask,
        input  out_valid, out_data, done_norm
    );

    modport slave (
        input  in_valid, inp_data, validity_mask,
        output out_valid, out_data, done_norm
    );
endinterface

// File: rtl/norm_lane.sv
// One lane of the normaliser: S1 subtract, S2 multiply, S3 shift + saturate
// (+ optional ReLU) and pass-through mux into the output register.
// Optional feature macro: NORM_RELU_EN (clamp negative normalised results to 0).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   sel_i       : 1 = normalise this sample, 0 = pass x through (sampled with x_i)
//   x_i         : input sample (signed)
//   mean_i      : mean used by S1 for the sample entering this cycle
//   inv_var_i   : inverse variance used by S2 (valid one cycle after x_i)
//   out_en_i    : load output register (a result leaves S2 this cycle)
//   y_o         : registered lane result, holds when out_en_i=0
module norm_lane
    import norm_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel_i,
    input  logic [DWIDTH-1:0] x_i,
    input  logic [DWIDTH-1:0] mean_i,
    input  logic [DWIDTH-1:0] inv_var_i,
    input  logic              out_en_i,
    output logic [DWIDTH-1:0] y_o
);

    localparam int unsigned SW = DWIDTH + 1;
    localparam int unsigned PW = 2 * DWIDTH + 2;
    localparam logic signed [PW-1:0] SAT_HI = PW'(sat_max(DWIDTH));
    localparam logic signed [PW-1:0] SAT_LO = PW'(sat_min(DWIDTH));

    logic signed [SW-1:0] diff_q;
    logic signed [PW-1:0] prod_q;
    logic [DWIDTH-1:0]    x1_q, x2_q;
    logic                 sel1_q, sel2_q;
    logic [DWIDTH-1:0]    y_q;

    logic signed [PW-1:0] diff_ext, coef_ext, shifted;
    logic [DWIDTH-1:0]    sat_val, norm_val, y_d;

    assign diff_ext = PW'(diff_q);
    assign coef_ext = PW'($signed(inv_var_i));

    // S1/S2 registers; raw sample and select ride along for the bypass path.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_q <= '0;
            prod_q <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            sel1_q <= 1'b0;
            sel2_q <= 1'b0;
            y_q    <= '0;
        end else begin
            diff_q <= SW'($signed(x_i)) - SW'($signed(mean_i));
            x1_q   <= x_i;
            sel1_q <= sel_i;
            prod_q <= diff_ext * coef_ext;
            x2_q   <= x1_q;
            sel2_q <= sel1_q;
            if (out_en_i) begin
                y_q <= y_d;
            end
        end
    end

    // S3: arithmetic shift, clamp to the signed DWIDTH range, select result.
    always_comb begin
        shifted = prod_q >>> FRAC_BITS;
        sat_val = DWIDTH'(shifted);
        if (shifted > SAT_HI) begin
            sat_val = DWIDTH'(SAT_HI);
        end else if (shifted < SAT_LO) begin
            sat_val = DWIDTH'(SAT_LO);
        end
`ifdef NORM_RELU_EN
        norm_val = sat_val[DWIDTH-1] ? '0 : sat_val;
`else
        norm_val = sat_val;
`endif
        y_d = sel2_q ? norm_val : x2_q;
    end

    assign y_o = y_q;

endmodule

// File: rtl/norm_pipe.sv
// Pipelined per-lane normaliser: y = sat((x - mean[l]) * inv_var[l] >>> FRAC_BITS),
// 3-cycle latency, 1 vector/cycle, run counting with a done_norm pulse.
// Optional feature macro: NORM_RELU_EN (see norm_lane).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable_norm  : 1 = normalise, 0 = bypass; sampled with each in_valid
//   mean         : per-lane mean, latched at run start
//   inv_var      : per-lane inverse variance (signed), latched at run start
//   vec_count    : vectors per run (0 treated as 1), latched at run start
//   bus          : norm_if slave (in_valid/inp_data/validity_mask in,
//                  out_valid/out_data/done_norm out)
module norm_pipe
    import norm_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned LANES     = 16,
    parameter int unsigned FRAC_BITS = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_norm,
    input  logic [LANES*DWIDTH-1:0] mean,
    input  logic [LANES*DWIDTH-1:0] inv_var,
    input  logic [CNT_W-1:0]        vec_count,
    norm_if.slave                   bus
);

    localparam int unsigned VW = LANES * DWIDTH;

    norm_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      target_q, target_d;
    logic [VW-1:0]         mean_q, mean_d;
    logic [VW-1:0]         inv_var_q, inv_var_d;
    logic [PIPE_DEPTH-1:0] vld_q;
    logic                  done_q;

    logic                  count_en;
    logic [VW-1:0]         mean_sel;
    logic [LANES-1:0]      lane_sel;
    logic [VW-1:0]         lane_y;

    assign count_en = bus.in_valid & enable_norm;

    // The starting vector is in S1 before mean_q is loaded, so IDLE uses the live mean.
    assign mean_sel = (state_q == IDLE) ? mean : mean_q;
    assign lane_sel = bus.validity_mask & {LANES{enable_norm}};

    // State, counter, coefficient latches and stage-valid shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            target_q  <= '0;
            mean_q    <= '0;
            inv_var_q <= '0;
            vld_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            mean_q    <= mean_d;
            inv_var_q <= inv_var_d;
            vld_q     <= {vld_q[PIPE_DEPTH-2:0], bus.in_valid};
            done_q    <= (state_d == DONE);
        end
    end

    // Run control: only normalised vectors count; extras in DRAIN/DONE pass uncounted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        mean_d    = mean_q;
        inv_var_d = inv_var_q;
        case (state_q)
            IDLE: begin
                if (count_en) begin
                    mean_d    = mean;
                    inv_var_d = inv_var;
                    target_d  = (vec_count == '0) ? CNT_W'(1) : vec_count;
                    cnt_d     = CNT_W'(1);
                    state_d   = (vec_count <= CNT_W'(1)) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (count_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == target_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last result is in the output register once S1/S2 are empty.
                if (vld_q[PIPE_DEPTH-2:0] == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        norm_lane #(
            .DWIDTH    (DWIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .sel_i     (lane_sel[l]),
            .x_i       (bus.inp_data[l*DWIDTH +: DWIDTH]),
            .mean_i    (mean_sel[l*DWIDTH +: DWIDTH]),
            .inv_var_i (inv_var_q[l*DWIDTH +: DWIDTH]),
            .out_en_i  (vld_q[PIPE_DEPTH-2]),
            .y_o       (lane_y[l*DWIDTH +: DWIDTH])
        );
    end

    assign bus.out_valid = vld_q[PIPE_DEPTH-1];
    assign bus.out_data  = lane_y;
    assign bus.done_norm = done_q;

endmodule
